// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding imem read, DEPTH-entry instruction queue, jump flush.
// Optional macro FETCH_BYPASS_EN presents a non-discarded ack to decode in the ack cycle when the queue is empty.
module instruction_fetch #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] next_pc,
    input  logic        jump,
    output logic        pc_we,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic          req_jump;
    logic          stale;
    logic          jump_d;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_ir [DEPTH];
    logic [31:0]   q_pc [DEPTH];

    logic ack_ok;
    logic flush;
    logic push;
    logic pop;
    logic q_nonempty;

    assign q_nonempty = (count != '0);
    assign flush      = jump & ~jump_d;
    // A response is stale if a redirect appeared after its request was issued.
    assign ack_ok     = (state == WAIT) & imem_ack & ~(stale | (jump & ~req_jump));
    assign pc_we      = ack_ok;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = ~q_nonempty & ~jump & ack_ok;
    assign ir_valid = (q_nonempty | bypass) & ~jump;
    assign ir       = bypass ? imem_rdata : q_ir[rd_ptr];
    assign ir_pc    = bypass ? imem_addr  : q_pc[rd_ptr];
    assign push     = ack_ok & ~(bypass & ir_ready);
    assign pop      = q_nonempty & ~jump & ir_ready;
`else
    assign ir_valid = q_nonempty & ~jump;
    assign ir       = q_ir[rd_ptr];
    assign ir_pc    = q_pc[rd_ptr];
    assign push     = ack_ok;
    assign pop      = ir_valid & ir_ready;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            req_jump  <= 1'b0;
            stale     <= 1'b0;
            jump_d    <= 1'b0;
        end else begin
            jump_d <= jump;
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= next_pc;
                        req_jump  <= jump;
                        stale     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (jump & ~req_jump) stale <= 1'b1;
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_ir   <= '{default: '0};
            q_pc   <= '{default: '0};
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                q_ir[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr] <= imem_addr;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push & ~pop) count <= count + CW'(1);
            else if (pop & ~push) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed redirect/reset scenarios plus a randomized run.
// The expected decode stream is program order from the last reset/jump target; a PC-unit model drives next_pc.
`timescale 1ns/1ps
module tb_instruction_fetch;
    localparam int unsigned DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] next_pc;
    logic        jump;
    logic        pc_we;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .next_pc(next_pc), .jump(jump), .pc_we(pc_we),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory contents; address 3 holds a recognisable word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'd3) return 32'hdeadbeef;
        return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
    endfunction

    // mode: 0 no ack, 1 ack tied to req, 2 random latency, 3 manual, 4 ack forced high
    int unsigned mode = 0;
    logic        ack_r = 1'b0;
    logic        manual_go = 1'b0;
    logic [31:0] tb_pc;
    logic [31:0] jtarget = '0;

    assign imem_rdata = mem_fn(imem_addr);
    assign imem_ack   = (mode == 1) ? imem_req : (mode == 4) ? 1'b1 : ack_r;
    assign next_pc    = jump ? jtarget : tb_pc + 32'd1;

    always @(posedge clk) begin
        #1;
        ack_r = imem_req && ((mode == 2 && $urandom_range(0, 2) == 0) || (mode == 3 && manual_go));
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) tb_pc <= 32'hffffffff;
        else if (pc_we) tb_pc <= next_pc;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_gen = '0;
    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    int          pcwe_cnt = 0;
    logic        jump_prev = 1'b0;
    logic        last_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    function automatic void sb_restart(input logic [31:0] start);
        exp_q.delete();
        exp_gen = start;
    endfunction

    // Monitor: compares every decode handshake and every accepted fetch.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (n_rst) begin
            while (exp_q.size() < 4) begin
                exp_q.push_back('{pc: exp_gen, word: mem_fn(exp_gen)});
                exp_gen = exp_gen + 32'd1;
            end
            if (ir_valid && ir_ready) begin
                e = exp_q.pop_front();
                check("ir_pc", ir_pc, e.pc);
                check("ir", ir, e.word);
                delivered++;
            end
            if (pc_we) begin
                check("fetch_addr", imem_addr, jump ? jtarget : tb_pc + 32'd1);
                check("pcwe_on_jump_rise", 32'(jump & ~jump_prev), 32'd0);
                pcwe_cnt++;
            end
            jump_prev = jump;
            last_we   = pc_we;
        end else begin
            jump_prev = 1'b0;
            last_we   = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        n_rst = 1'b0;
        jump  = 1'b0;
        sb_restart(32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic manual_ack(output logic we, output logic [31:0] addr, output logic v);
        bit got = 0;
        we = 1'b0; addr = '0; v = 1'b0;
        @(negedge clk);
        manual_go = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (imem_ack && imem_req) begin
                got = 1; we = pc_we; addr = imem_addr; v = ir_valid;
            end
        end
        manual_go = 1'b0;
        if (!got) timeout_fail("manual_ack");
    endtask

    task automatic wait_req(output logic [31:0] addr);
        bit got = 0;
        addr = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (imem_req) begin got = 1; addr = imem_addr; end
        end
        if (!got) timeout_fail("wait_req");
    endtask

    task automatic raise_jump(input logic [31:0] t);
        @(posedge clk); #1;
        jtarget = t;
        jump    = 1'b1;
        sb_restart(t);
    endtask

    task automatic release_jump();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (pc_we) got = 1;
        end
        if (!got) timeout_fail("jump_ack");
        @(posedge clk); #1;
        jump = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, v, v0, v1;
        logic [31:0] a, ir0, ir1, pc0, pc1;
        int          n, first_i, cnt, gap, jump_age;

        n_rst = 1'b0; jump = 1'b0; ir_ready = 1'b0;
        sb_restart(32'd0);
        #12;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_pc_we", 32'(pc_we), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_ir_pc", ir_pc, 32'd0);

        // Ack tied to req, decode always ready: sequential fetch at peak rate.
        ir_ready = 1'b1; mode = 1;
        @(posedge clk); #1 n_rst = 1'b1;
        n = 0; first_i = -10;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (i == first_i + 1) check("valid_after_first_ack", 32'(ir_valid), 32'(!BYP));
            if (pc_we) begin
                check("seq_addr", imem_addr, 32'(n));
                if (n == 0) begin
                    check("valid_in_first_ack", 32'(ir_valid), 32'(BYP));
                    first_i = i;
                end
                n++;
            end
        end
        check("seq_count", 32'(n), 32'd4);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (pc_we) cnt++;
        end
        check("throughput_20cyc", 32'(cnt), 32'd10);

        // Decode stalled: queue fills after two fetches, then no requests.
        @(posedge clk); #1 ir_ready = 1'b0;
        do_reset();
        cnt = 0; n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pc_we) cnt++;
            if (i >= 8 && imem_req) n++;
        end
        check("full_fetch_count", 32'(cnt), 32'd2);
        check("full_no_req", 32'(n), 32'd0);
        @(posedge clk); #1 ir_ready = 1'b1;
        wait_req(a);
        check("after_drain_addr", a, 32'd2);
        repeat (4) @(negedge clk);

        // Redirect while the request for address 5 is outstanding.
        mode = 3;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            manual_ack(we, a, v);
            check("pre_jump_we", 32'(we), 32'd1);
            check("pre_jump_addr", a, 32'(k));
        end
        wait_req(a);
        check("outstanding_addr", a, 32'd5);
        raise_jump(32'h40);
        repeat (2) @(negedge clk);
        manual_ack(we, a, v);
        check("stale_ack_addr", a, 32'd5);
        check("stale_ack_pc_we", 32'(we), 32'd0);
        manual_ack(we, a, v);
        check("target_addr", a, 32'h40);
        check("target_pc_we", 32'(we), 32'd1);
        check("valid_while_jump", 32'(v), 32'd0);
        @(posedge clk); #1 jump = 1'b0;
        @(negedge clk);
        check("target_valid", 32'(ir_valid), 32'd1);
        check("target_ir_pc", ir_pc, 32'h40);
        repeat (3) @(negedge clk);

        // Jump rises in the ack cycle of address 7 with a queued entry.
        do_reset();
        for (int k = 0; k < 6; k++) manual_ack(we, a, v);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 ir_ready = 1'b0;
        manual_ack(we, a, v);
        check("queued_addr", a, 32'd6);
        wait_req(a);
        check("ack_jump_addr", a, 32'd7);
        @(negedge clk); manual_go = 1'b1;
        @(posedge clk); #1;
        jtarget = 32'h80; jump = 1'b1; sb_restart(32'h80);
        @(negedge clk);
        manual_go = 1'b0;
        check("ack_jump_ack", 32'(imem_ack), 32'd1);
        check("ack_jump_pc_we", 32'(pc_we), 32'd0);
        check("ack_jump_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check("flushed_valid", 32'(ir_valid), 32'd0);
        @(posedge clk); #1 ir_ready = 1'b1; mode = 1;
        release_jump();
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(negedge clk);
            if (ir_valid) begin n = 1; check("flush_first_pc", ir_pc, 32'h80); end
        end
        if (n == 0) timeout_fail("flush_first_valid");

        // Reset pulsed while a request is outstanding; acks during and right after reset are ignored.
        mode = 3;
        do_reset();
        wait_req(a);
        #2;
        n_rst = 1'b0; mode = 4; sb_restart(32'd0);
        #1;
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_ir_valid", 32'(ir_valid), 32'd0);
        check("midrst_pc_we", 32'(pc_we), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("idle_ack_ignored", 32'(pc_we), 32'd0);
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (pc_we) begin n = 1; check("post_rst_addr", imem_addr, 32'd0); end
        end
        if (n == 0) timeout_fail("post_rst_fetch");
        mode = 3;

        // Word at address 3 fetched into an empty queue with decode ready.
        do_reset();
        for (int k = 0; k < 3; k++) manual_ack(we, a, v);
        repeat (3) @(negedge clk);
        @(negedge clk); manual_go = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(negedge clk);
            if (imem_ack && imem_req) begin
                n = 1; v0 = ir_valid; ir0 = ir; pc0 = ir_pc;
            end
        end
        manual_go = 1'b0;
        if (n == 0) timeout_fail("word3_ack");
        @(negedge clk);
        v1 = ir_valid; ir1 = ir; pc1 = ir_pc;
        check("word3_valid_ack", 32'(v0), 32'(BYP));
        check("word3_valid_next", 32'(v1), 32'(!BYP));
        check("word3_ir", BYP ? ir0 : ir1, 32'hdeadbeef);
        check("word3_ir_pc", BYP ? pc0 : pc1, 32'd3);

        // Randomized run: random ack latency, decode backpressure and redirects.
        mode = 2;
        do_reset();
        delivered = 0; gap = 5; jump_age = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            ir_ready = ($urandom_range(0, 3) != 0);
            if (jump) begin
                jump_age++;
                if (last_we) begin
                    jump = 1'b0; gap = 3 + int'($urandom_range(0, 5));
                end else if (jump_age > 300) begin
                    timeout_fail("rand_jump_ack");
                    jump = 1'b0; gap = 3;
                end
            end else if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 30) == 0) begin
                jtarget = $urandom; jump = 1'b1; jump_age = 0;
                sb_restart(jtarget);
            end
        end
        check("rand_progress", 32'(delivered >= 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
